// File: rtl/partial_store_unit_pkg.sv
// Shared store-path constants: funct3 encodings, base byte-enable masks and FSM state type.
// Mirrors the store defines kept in the shared opcode header so the RTL has no include-path dependency.
package partial_store_unit_pkg;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  localparam logic [3:0] STORE_WE_B = 4'b0001;
  localparam logic [3:0] STORE_WE_H = 4'b0011;
  localparam logic [3:0] STORE_WE_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  function automatic logic [31:0] word_base(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/partial_store_unit_lane_shift.sv
// Combinational lane placement: base mask and width-masked data shifted by the byte offset.
// The 8-bit mask / 64-bit data span two words so an unaligned access falls into the HI half.
module store_lane_shift
  import partial_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic        illegal
);

  logic [3:0]  base;
  logic [31:0] data_m;

  always_comb begin
    base    = 4'b0000;
    data_m  = 32'h0;
    illegal = 1'b0;
    case (funct3)
      FNC_SB: begin
        base   = STORE_WE_B;
        data_m = {24'h0, data[7:0]};
      end
      FNC_SH: begin
        base   = STORE_WE_H;
        data_m = {16'h0, data[15:0]};
      end
      FNC_SW: begin
        base   = STORE_WE_W;
        data_m = data;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign mask8  = {4'b0000, base} << offset;
  assign data64 = {32'h0, data_m} << {offset, 3'b000};

endmodule

// File: rtl/partial_store_unit.sv
// Store alignment unit: accepts SB/SH/SW, emits one or two word-aligned write beats.
// state   | meaning
// IDLE    | ready for a request; illegal funct3 is absorbed here with an st_err pulse
// LO      | presenting the low-word beat, waiting for mem_ready
// HI      | presenting the wrap/next-word beat of a split store
module partial_store_unit
  import partial_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        st_split,
  output logic        st_err
);

  state_t state, state_next;

  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        illegal;
  logic        accept;

  logic [31:0] lo_addr, hi_addr, lo_wdata, hi_wdata;
  logic [3:0]  lo_we, hi_we;
  logic        hi_needed;

  store_lane_shift u_shift (
    .funct3  (st_funct3),
    .offset  (st_addr[1:0]),
    .data    (st_data),
    .mask8   (mask8),
    .data64  (data64),
    .illegal (illegal)
  );

  assign accept    = st_valid && st_ready;
  assign hi_needed = (hi_we != 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && !illegal) state_next = ST_LO;
      ST_LO:   if (mem_ready) state_next = hi_needed ? ST_HI : ST_IDLE;
      ST_HI:   if (mem_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Both beats are captured at accept so the HI beat never depends on live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_addr  <= 32'h0;
      hi_addr  <= 32'h0;
      lo_wdata <= 32'h0;
      hi_wdata <= 32'h0;
      lo_we    <= 4'b0000;
      hi_we    <= 4'b0000;
      st_split <= 1'b0;
      st_err   <= 1'b0;
    end else begin
      st_split <= accept && !illegal && (mask8[7:4] != 4'b0000);
      st_err   <= accept && illegal;
      if (accept && !illegal) begin
        lo_addr  <= word_base(st_addr);
        hi_addr  <= word_base(st_addr) + 32'd4;
        lo_wdata <= data64[31:0];
        hi_wdata <= data64[63:32];
        lo_we    <= mask8[3:0];
        hi_we    <= mask8[7:4];
      end
    end
  end

  always_comb begin
    st_ready  = (state == ST_IDLE) && !rst;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 4'b0000;
    case (state)
      ST_LO: begin
        mem_valid = 1'b1;
        mem_addr  = lo_addr;
        mem_wdata = lo_wdata;
        mem_we    = lo_we;
      end
      ST_HI: begin
        mem_valid = 1'b1;
        mem_addr  = hi_addr;
        mem_wdata = hi_wdata;
        mem_we    = hi_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_partial_store_unit.sv
// Directed bench for partial_store_unit: hand-computed beats for aligned, unaligned,
// wrapping, stalled, illegal and reset-interrupted stores.
module tb_partial_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        st_split;
  logic        st_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  partial_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .st_split  (st_split),
    .st_err    (st_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] we);
    check_val({tag, "_valid"}, {31'h0, mem_valid}, 32'h1);
    check_val({tag, "_addr"},  mem_addr, a);
    check_val({tag, "_wdata"}, mem_wdata, d);
    check_val({tag, "_we"},    {28'h0, mem_we}, {28'h0, we});
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, {31'h0, mem_valid}, 32'h0);
    check_val({tag, "_we"},    {28'h0, mem_we}, 32'h0);
    check_val({tag, "_ready"}, {31'h0, st_ready}, 32'h1);
  endtask

  // Drives a request for one accepting edge; caller is just after a negedge in IDLE.
  task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    st_valid  = 1'b0;
    st_funct3 = 3'b000;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'h0, st_ready}, 32'h0);
    check_val("rst_valid", {31'h0, mem_valid}, 32'h0);
    check_val("rst_we",    {28'h0, mem_we}, 32'h0);
    check_val("rst_addr",  mem_addr, 32'h0);
    check_val("rst_wdata", mem_wdata, 32'h0);
    check_val("rst_split", {31'h0, st_split}, 32'h0);
    check_val("rst_err",   {31'h0, st_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // SB at offset 1
    @(negedge clk);
    check_val("post_rst_ready", {31'h0, st_ready}, 32'h1);
    send_req(3'b000, 32'h0000_1001, 32'h1234_5678);
    @(negedge clk);
    check_beat("sb_lo", 32'h0000_1000, 32'h0000_7800, 4'b0010);
    check_val("sb_split", {31'h0, st_split}, 32'h0);
    check_val("sb_busy",  {31'h0, st_ready}, 32'h0);
    @(negedge clk);
    check_idle("sb_done");

    // SH at offset 2
    send_req(3'b001, 32'h0000_2002, 32'hABCD_1234);
    @(negedge clk);
    check_beat("sh_lo", 32'h0000_2000, 32'h1234_0000, 4'b1100);
    check_val("sh_split", {31'h0, st_split}, 32'h0);
    @(negedge clk);
    check_idle("sh_done");

    // SW at offset 1 splits; a request held during HI waits for IDLE
    send_req(3'b010, 32'h0000_3001, 32'h1122_3344);
    @(negedge clk);
    check_beat("sw1_lo", 32'h0000_3000, 32'h2233_4400, 4'b1110);
    check_val("sw1_split", {31'h0, st_split}, 32'h1);
    @(negedge clk);
    check_beat("sw1_hi", 32'h0000_3004, 32'h0000_0011, 4'b0001);
    check_val("sw1_split_once", {31'h0, st_split}, 32'h0);
    check_val("sw1_hi_ready", {31'h0, st_ready}, 32'h0);
    st_valid  = 1'b1;
    st_funct3 = 3'b000;
    st_addr   = 32'h0000_6003;
    st_data   = 32'h0000_00A5;
    @(negedge clk);
    check_idle("hold_idle");
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    check_beat("hold_lo", 32'h0000_6000, 32'hA500_0000, 4'b1000);
    @(negedge clk);
    check_idle("hold_done");

    // SH wrapping past the top of the address space
    send_req(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
    @(negedge clk);
    check_beat("wrap_lo", 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
    check_val("wrap_split", {31'h0, st_split}, 32'h1);
    @(negedge clk);
    check_beat("wrap_hi", 32'h0000_0000, 32'h0000_00BE, 4'b0001);
    @(negedge clk);
    check_idle("wrap_done");

    // Aligned SW stalled for 3 cycles
    mem_ready = 1'b0;
    send_req(3'b010, 32'h0000_4000, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_beat($sformatf("stall%0d", i), 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
      check_val($sformatf("stall%0d_ready", i), {31'h0, st_ready}, 32'h0);
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    check_idle("stall_done");

    // Illegal funct3
    send_req(3'b011, 32'h0000_5000, 32'h5555_5555);
    @(negedge clk);
    check_val("ill_err",   {31'h0, st_err}, 32'h1);
    check_val("ill_split", {31'h0, st_split}, 32'h0);
    check_idle("ill_c1");
    @(negedge clk);
    check_val("ill_err_once", {31'h0, st_err}, 32'h0);
    check_idle("ill_c2");

    // Reset during HI beat of a split SW
    send_req(3'b010, 32'h0000_7002, 32'hDEAD_BEEF);
    @(negedge clk);
    check_beat("rsw_lo", 32'h0000_7000, 32'hBEEF_0000, 4'b1100);
    @(negedge clk);
    check_beat("rsw_hi", 32'h0000_7004, 32'h0000_DEAD, 4'b0011);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_val("rsw_drop_valid", {31'h0, mem_valid}, 32'h0);
    check_val("rsw_drop_we",    {28'h0, mem_we}, 32'h0);
    check_val("rsw_rst_ready",  {31'h0, st_ready}, 32'h0);
    rst       = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check_idle("rsw_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
